posit_accumulator: RTL and testbench

- Sequential reduction stage built around the combinational Posit_Adder (N=32, ES=4).
- Accepts a stream of posit operands over valid/ready and sums each group delimited by in_last.
- Feeds Posit_Adder with IN1 = running sum and IN2 = incoming operand, and registers OUT as the new running sum.
- Presents each group total downstream with a count and a NaR flag. Used for dot-product and precision/associativity sweeps.

---
 rtl/posit_accumulator.sv | 200 ++++++++++++++++++++
 tb/tb_posit_accumulator.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/posit_accumulator.sv
// Posit_Adder: combinational posit<N,ES> add, round-to-nearest-even on the bit string.
// Zero latency; no handshake, saturates to minpos/maxpos, NaR in gives NaR out.
module Posit_Adder #(
    parameter int N  = 32,
    parameter int ES = 4
) (
    input  logic [N-1:0] IN1,
    input  logic [N-1:0] IN2,
    output logic [N-1:0] OUT
);
    localparam int FW = N - 1 - ES;
    localparam int MW = FW + 5;
    localparam int SW = $clog2(N) + ES + 3;
    localparam int EW = ES + MW + N;
    localparam logic [N-1:0] NAR = {1'b1, {(N-1){1'b0}}};

    typedef struct packed {
        logic                 sgn;
        logic                 zero;
        logic                 nar;
        logic signed [SW-1:0] scale;
        logic [FW-1:0]        frac;
    } dec_t;

    function automatic dec_t decode(input logic [N-1:0] w);
        dec_t           d;
        logic [N-2:0]   body;
        logic [N-2:0]   sh;
        logic           r0;
        logic           run;
        int             m;
        int             k;
        d.sgn  = w[N-1];
        d.zero = (w == '0);
        d.nar  = (w == NAR);
        body   = (N-1)'(w[N-1] ? -w : w);
        r0     = body[N-2];
        m      = 0;
        run    = 1'b1;
        for (int i = N - 2; i >= 0; i--) begin
            if (run && body[i] == r0) m++;
            else run = 1'b0;
        end
        k       = r0 ? m - 1 : -m;
        sh      = body << (m + 1);
        d.scale = SW'(k * (1 << ES) + int'(sh[N-2 -: ES]));
        d.frac  = sh[N-2-ES:0];
        return d;
    endfunction

    // Regime is built by arithmetic-shifting a 10/01 seed so the run fills in by sign extension.
    function automatic logic [N-1:0] encode(input logic sgn, input logic signed [SW-1:0] scale,
                                            input logic [MW-2:0] frac);
        logic signed [SW-1:0] k;
        logic [EW-1:0]        v;
        logic [N-2:0]         body;
        int                   sh;
        k = scale >>> ES;
        if (k >= N - 2) begin
            body = '1;
        end else if (k < -(N - 2)) begin
            body = {{(N-2){1'b0}}, 1'b1};
        end else begin
            v    = {(k >= 0) ? 2'b10 : 2'b01, scale[ES-1:0], frac, {(N-1){1'b0}}};
            sh   = (k >= 0) ? int'(k) : -int'(k) - 1;
            v    = $signed(v) >>> sh;
            body = v[EW-1 -: N-1];
            body = body + (N-1)'(v[EW-N] & (body[0] | (|v[EW-N-1:0])));
        end
        return sgn ? -{1'b0, body} : {1'b0, body};
    endfunction

    dec_t                 w_a, w_b, w_big, w_sml;
    logic [MW-1:0]        w_ma, w_mb, w_mbs, w_sum;
    logic [2*MW-1:0]      w_wide;
    logic [MW-2:0]        w_frac;
    logic signed [SW-1:0] w_scale;
    logic                 w_swap;
    int                   w_sh, w_lead;

    always_comb begin
        w_a    = decode(IN1);
        w_b    = decode(IN2);
        w_swap = (w_b.scale > w_a.scale) || (w_b.scale == w_a.scale && w_b.frac > w_a.frac);
        w_big  = w_swap ? w_b : w_a;
        w_sml  = w_swap ? w_a : w_b;
        w_ma   = {2'b01, w_big.frac, 3'b000};
        w_mb   = {2'b01, w_sml.frac, 3'b000};
        w_sh   = int'(w_big.scale) - int'(w_sml.scale);
        if (w_sh > MW) w_sh = MW;
        // Shifted-out bits are jammed into the LSB, which sits below the rounding guard.
        w_wide = {w_mb, {MW{1'b0}}} >> w_sh;
        w_mbs  = w_wide[2*MW-1:MW] | {{(MW-1){1'b0}}, |w_wide[MW-1:0]};
        w_sum  = (w_big.sgn != w_sml.sgn) ? w_ma - w_mbs : w_ma + w_mbs;
        w_lead = 0;
        for (int i = 0; i < MW; i++) begin
            if (w_sum[i]) w_lead = i;
        end
        w_frac  = (MW-1)'(w_sum << (MW - 1 - w_lead));
        w_scale = w_big.scale + SW'(w_lead - (MW - 2));
        if (w_a.nar || w_b.nar)  OUT = NAR;
        else if (w_a.zero)       OUT = IN2;
        else if (w_b.zero)       OUT = IN1;
        else if (w_sum == '0)    OUT = '0;
        else                     OUT = encode(w_big.sgn, w_scale, w_frac);
    end
endmodule

// posit_accumulator: sums posit beats per in_last-delimited group, one beat per cycle.
// Result valid 1 cycle after the last beat; in_ready low while a result waits for out_ready.
module posit_accumulator #(
    parameter int N  = 32,
    parameter int ES = 4,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  in_data,
    input  logic          in_last,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  out_data,
    output logic [CW-1:0] out_count,
    output logic          out_nar
);
    localparam logic [N-1:0] NAR = {1'b1, {(N-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_ACC, S_OUT} state_t;

    state_t        r_state;
    logic [N-1:0]  r_acc, r_out_dat;
    logic [CW-1:0] r_cnt, r_out_cnt;
    logic          r_nar, r_out_nar, r_out_vld;

    logic [N-1:0]  w_sum, w_acc_nxt;
    logic [CW-1:0] w_cnt_nxt;
    logic          w_nar_nxt, w_take, w_first;

    Posit_Adder #(.N(N), .ES(ES)) u_add (
        .IN1 (r_acc),
        .IN2 (in_data),
        .OUT (w_sum)
    );

    assign in_ready  = !reset && (r_state != S_OUT);
    assign w_take    = in_valid && in_ready;
    assign w_first   = (r_state == S_IDLE);
    assign w_nar_nxt = w_first ? (in_data == NAR) : (r_nar || in_data == NAR || w_sum == NAR);
    assign w_acc_nxt = w_first ? in_data : (w_nar_nxt ? NAR : w_sum);
    assign w_cnt_nxt = w_first ? CW'(1) : ((r_cnt == '1) ? r_cnt : r_cnt + CW'(1));

    assign out_valid = r_out_vld;
    assign out_data  = r_out_dat;
    assign out_count = r_out_cnt;
    assign out_nar   = r_out_nar;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_nar     <= 1'b0;
            r_out_vld <= 1'b0;
            r_out_dat <= '0;
            r_out_cnt <= '0;
            r_out_nar <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_ACC: begin
                    if (w_take) begin
                        r_acc <= w_acc_nxt;
                        r_cnt <= w_cnt_nxt;
                        r_nar <= w_nar_nxt;
                        if (in_last) begin
                            r_state   <= S_OUT;
                            r_out_vld <= 1'b1;
                            r_out_dat <= w_acc_nxt;
                            r_out_cnt <= w_cnt_nxt;
                            r_out_nar <= w_nar_nxt;
                        end else begin
                            r_state <= S_ACC;
                        end
                    end
                end
                S_OUT: begin
                    if (out_ready) begin
                        r_state   <= S_IDLE;
                        r_out_vld <= 1'b0;
                        r_acc     <= '0;
                        r_cnt     <= '0;
                        r_nar     <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_posit_accumulator.sv
// Bench for posit_accumulator: directed steps plus random groups against a real-valued posit model.
module tb_posit_accumulator;
    localparam logic [31:0] NAR = 32'h80000000;

    logic        clk = 1'b0;
    logic        reset, in_valid, in_ready, in_last, out_valid, out_ready, out_nar;
    logic [31:0] in_data, out_data;
    logic [7:0]  out_count;
    int          tests = 0;
    int          fails = 0;

    posit_accumulator #(.N(32), .ES(4), .CW(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_count (out_count),
        .out_nar   (out_nar)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic real p2(input int s);
        real r = 1.0;
        if (s >= 0) repeat (s) r = r * 2.0;
        else repeat (-s) r = r / 2.0;
        return r;
    endfunction

    // value = (1 + fraction) * 2^(16*k + e), missing exponent bits read as zero
    function automatic real pdec(input logic [31:0] c);
        logic [31:0] a;
        logic        r0, run;
        int          m, k, e, pos;
        real         f, w;
        if (c == 32'h0) return 0.0;
        a = c[31] ? -c : c;
        r0 = a[30];
        m = 0;
        run = 1'b1;
        for (int i = 30; i >= 0; i--) begin
            if (run && a[i] == r0) m++;
            else run = 1'b0;
        end
        k = r0 ? m - 1 : -m;
        pos = 29 - m;
        e = 0;
        for (int j = 0; j < 4; j++) begin
            e = e * 2 + ((pos >= 0) ? int'(a[pos]) : 0);
            pos--;
        end
        f = 1.0;
        w = 0.5;
        while (pos >= 0) begin
            if (a[pos]) f = f + w;
            w = w / 2.0;
            pos--;
        end
        f = f * p2(16 * k + e);
        return c[31] ? -f : f;
    endfunction

    // nearest posit by search over the monotonic code space, ties to the even code
    function automatic logic [31:0] penc(input real x);
        logic [31:0] lo, hi, mid, c;
        real         a, dl, du;
        if (x == 0.0) return 32'h0;
        a = (x < 0.0) ? -x : x;
        lo = 32'h1;
        hi = 32'h7FFFFFFF;
        while (lo < hi) begin
            mid = lo + (hi - lo + 1) / 2;
            if (pdec(mid) <= a) lo = mid;
            else hi = mid - 1;
        end
        c = lo;
        if (c != 32'h7FFFFFFF) begin
            dl = a - pdec(c);
            du = pdec(c + 1) - a;
            if (du < dl || (du == dl && c[0])) c = c + 1;
        end
        return (x < 0.0) ? -c : c;
    endfunction

    function automatic logic [31:0] rand_code();
        int  r, s;
        real x;
        r = int'($urandom_range(0, 31));
        if (r == 0) return 32'h0;
        if (r == 1) return NAR;
        s = int'($urandom_range(0, 60)) - 30;
        x = p2(s) * (1.0 + real'($urandom) / 4294967296.0);
        if ($urandom_range(0, 1) == 1) x = -x;
        return penc(x);
    endfunction

    task automatic send(input logic [31:0] d, input logic last);
        int t = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        while (in_ready !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) check("send_ready", {31'b0, in_ready}, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic expect_result(input string tag, input logic [31:0] d, input int c, input logic n);
        int t = 0;
        while (out_valid !== 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        check({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
        check({tag, "_data"}, out_data, d);
        check({tag, "_count"}, {24'b0, out_count}, 32'(c));
        check({tag, "_nar"}, {31'b0, out_nar}, {31'b0, n});
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_drain"}, {30'b0, out_valid, in_ready}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int          len;
        logic [31:0] acc, code;
        logic        nar;

        reset = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_in_ready_low", {31'b0, in_ready}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        check("rst_out_data", out_data, 32'h0);
        check("rst_out_count", {24'b0, out_count}, 32'd0);

        send(32'h40000000, 1'b0);
        send(32'h40000000, 1'b1);
        check("two_latency", {31'b0, out_valid}, 32'd1);
        expect_result("two", 32'h42000000, 2, 1'b0);

        for (int i = 0; i < 4; i++) send(32'h40000000, i == 3);
        for (int i = 0; i < 5; i++) begin
            check("hold_data", out_data, 32'h44000000);
            check("hold_ready", {30'b0, in_ready, out_valid}, 32'd1);
            @(negedge clk);
        end
        expect_result("four", 32'h44000000, 4, 1'b0);

        send(32'h40000000, 1'b0);
        send(32'hC0000000, 1'b1);
        expect_result("cancel", 32'h0, 2, 1'b0);
        send(32'h40000000, 1'b0);
        send(NAR, 1'b0);
        send(32'h42000000, 1'b1);
        expect_result("nar", NAR, 3, 1'b1);

        send(32'b00000000000010110011111110010000, 1'b1);
        expect_result("single", 32'b00000000000010110011111110010000, 1, 1'b0);
        for (int i = 0; i < 300; i++) send(32'h0, i == 299);
        expect_result("sat", 32'h0, 255, 1'b0);

        for (int i = 0; i < 3; i++) send(32'h40000000, 1'b0);
        #2 reset = 1'b1;
        #1 check("abort_async", {30'b0, out_valid, in_ready}, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("abort_no_out", {30'b0, out_valid, in_ready}, 32'd1);
        send(32'h40000000, 1'b0);
        send(32'h40000000, 1'b1);
        expect_result("after_abort", 32'h42000000, 2, 1'b0);

        for (int g = 0; g < 25; g++) begin
            len = int'($urandom_range(1, 6));
            acc = 32'h0;
            nar = 1'b0;
            for (int i = 0; i < len; i++) begin
                code = rand_code();
                if (i == 0) begin
                    acc = code;
                    nar = (code == NAR);
                end else begin
                    nar = nar || (code == NAR);
                    acc = nar ? NAR : penc(pdec(acc) + pdec(code));
                end
                send(code, i == len - 1);
            end
            check("rand_latency", {31'b0, out_valid}, 32'd1);
            expect_result("rand", acc, len, nar);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
